// File: rtl/ahb_lite_decoder_pkg.sv
// rtl/ahb_lite_decoder_pkg.sv - shared AHB-Lite constants, default memory map and default-slave states
package ahb_lite_decoder_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Slave 0 reset ROM, slave 1 RAM, slave 2 GPIO; slave i lives at [32*i +: 32]
  localparam int unsigned DEF_NSLAVE = 3;
  localparam logic [95:0] DEF_SLV_BASE = {32'h1F80_0000, 32'h0000_0000, 32'h1FC0_0000};
  localparam logic [95:0] DEF_SLV_MASK = {32'hFFFF_0000, 32'hFFFC_0000, 32'hFFFF_C000};

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_lite_default_slave.sv
// rtl/ahb_lite_default_slave.sv - answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response
module ahb_lite_default_slave
  import ahb_lite_decoder_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HREADY,
  input  logic       sel,
  input  logic [1:0] HTRANS,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_e state_q, state_d;
  logic      err_req;

  assign err_req = HREADY && sel && is_active(HTRANS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DS_OK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      DS_OK: begin
        if (err_req) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        // Last error cycle is also an address phase; a fresh unmapped transfer restarts the error
        HRESP   = HRESP_ERROR;
        state_d = err_req ? DS_ERR1 : DS_OK;
      end
      default: state_d = DS_OK;
    endcase
  end

endmodule

// File: rtl/ahb_lite_decoder.sv
// rtl/ahb_lite_decoder.sv - AHB-Lite address decoder and data-phase response multiplexer
module ahb_lite_decoder
  import ahb_lite_decoder_pkg::*;
#(
  parameter int unsigned              NSLAVE   = DEF_NSLAVE,
  parameter logic [32*NSLAVE-1:0]     SLV_BASE = DEF_SLV_BASE,
  parameter logic [32*NSLAVE-1:0]     SLV_MASK = DEF_SLV_MASK
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  output logic [31:0]            HRDATA,
  output logic                   HREADY,
  output logic                   HRESP,
  output logic [NSLAVE-1:0]      HSEL_S,
  input  logic [32*NSLAVE-1:0]   HRDATA_S,
  input  logic [NSLAVE-1:0]      HREADYOUT_S,
  input  logic [NSLAVE-1:0]      HRESP_S
);

  logic [NSLAVE-1:0] hit;
  logic [NSLAVE-1:0] dsel_q, dsel_d;
  logic              ddef_q, ddef_d;
  logic              unmapped;
  logic              ds_hreadyout, ds_hresp;

  for (genvar i = 0; i < NSLAVE; i++) begin : g_hit
    assign hit[i] = (HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32];
  end

  // Walk from the top down so the lowest-index overlapping slave ends up owning the address
  always_comb begin
    HSEL_S = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if (hit[i]) begin
        HSEL_S    = '0;
        HSEL_S[i] = 1'b1;
      end
    end
  end

  assign unmapped = (HSEL_S == '0);

  always_comb begin
    dsel_d = dsel_q;
    ddef_d = ddef_q;
    if (HREADY) begin
      dsel_d = HSEL_S;
      ddef_d = unmapped && is_active(HTRANS);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= '0;
      ddef_q <= 1'b0;
    end else begin
      dsel_q <= dsel_d;
      ddef_q <= ddef_d;
    end
  end

  ahb_lite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HREADY    (HREADY),
    .sel       (unmapped),
    .HTRANS    (HTRANS),
    .HREADYOUT (ds_hreadyout),
    .HRESP     (ds_hresp)
  );

  always_comb begin
    HRDATA = '0;
    HREADY = ds_hreadyout;
    HRESP  = ds_hresp;
    if (!ddef_q) begin
      for (int i = 0; i < NSLAVE; i++) begin
        if (dsel_q[i]) begin
          HRDATA = HRDATA_S[32*i +: 32];
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_decoder.sv
// tb/tb_ahb_lite_decoder.sv - directed scoreboard bench for the AHB-Lite decoder
module tb_ahb_lite_decoder;
  import ahb_lite_decoder_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [2:0]  HSEL_S;
  logic [95:0] HRDATA_S;
  logic [2:0]  HREADYOUT_S;
  logic [2:0]  HRESP_S;

  logic [31:0] ov_hrdata;
  logic        ov_hready;
  logic        ov_hresp;
  logic [2:0]  ov_hsel;

  always #5 HCLK = ~HCLK;

  ahb_lite_decoder dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HSEL_S      (HSEL_S),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S)
  );

  ahb_lite_decoder #(
    .NSLAVE   (3),
    .SLV_BASE ({32'h1F80_0000, 32'h1FC0_0000, 32'h1FC0_0000})
  ) dut_ov (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HRDATA      (ov_hrdata),
    .HREADY      (ov_hready),
    .HRESP       (ov_hresp),
    .HSEL_S      (ov_hsel),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S)
  );

  typedef struct {
    string       nm;
    logic [2:0]  hsel;
    logic [2:0]  hov;
    logic        rdy;
    logic        rsp;
    logic [31:0] dat;
    bit          cd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge HCLK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.nm, ".hsel"},   32'(HSEL_S),  32'(mon_e.hsel));
      chk({mon_e.nm, ".hsel_ov"}, 32'(ov_hsel), 32'(mon_e.hov));
      chk({mon_e.nm, ".hready"}, 32'(HREADY),  32'(mon_e.rdy));
      chk({mon_e.nm, ".hresp"},  32'(HRESP),   32'(mon_e.rsp));
      if (mon_e.cd) chk({mon_e.nm, ".hrdata"}, HRDATA, mon_e.dat);
    end
  end

  task automatic step(input string nm, input logic rstn, input bit rst_mid,
                      input logic [31:0] a, input logic [1:0] t,
                      input logic [2:0] rdy_s, input logic [2:0] rsp_s,
                      input logic [2:0] e_hsel, input logic [2:0] e_hov,
                      input logic e_rdy, input logic e_rsp,
                      input logic [31:0] e_dat, input bit cd);
    exp_t e;
    @(posedge HCLK);
    #1;
    HRESETn     = rstn;
    HADDR       = a;
    HTRANS      = t;
    HREADYOUT_S = rdy_s;
    HRESP_S     = rsp_s;
    e.nm   = nm;
    e.hsel = e_hsel;
    e.hov  = e_hov;
    e.rdy  = e_rdy;
    e.rsp  = e_rsp;
    e.dat  = e_dat;
    e.cd   = cd;
    sb.push_back(e);
    if (rst_mid) begin
      #1;
      HRESETn = 1'b0;
    end
  endtask

  initial begin
    HRESETn     = 1'b0;
    HADDR       = 32'h1FC0_0010;
    HTRANS      = HTRANS_IDLE;
    HRDATA_S    = {32'h6A10_0002, 32'hDEAD_BEEF, 32'hC0DE_0000};
    HREADYOUT_S = 3'b111;
    HRESP_S     = 3'b000;

    //   name            rstn mid addr           htrans         rdy_s   rsp_s   hsel    hov     rdy   rsp   hrdata         cd
    step("rst",          0,   0,  32'h1FC0_0010, HTRANS_IDLE,   3'b111, 3'b000, 3'b001, 3'b001, 1'b1, 1'b0, 32'h0,         1);
    step("ram_addr",     1,   0,  32'h0000_0040, HTRANS_NONSEQ, 3'b111, 3'b000, 3'b010, 3'b000, 1'b1, 1'b0, 32'h0,         1);
    step("ram_wait1",    1,   0,  32'h4000_0000, HTRANS_IDLE,   3'b101, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0,         0);
    step("ram_wait2",    1,   0,  32'h4000_0000, HTRANS_IDLE,   3'b101, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0,         0);
    step("ram_data",     1,   0,  32'h4000_0000, HTRANS_IDLE,   3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 32'hDEAD_BEEF, 1);
    step("idle_unmap",   1,   0,  32'h4000_0000, HTRANS_NONSEQ, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 32'h0,         1);
    step("err1",         1,   0,  32'h4000_0000, HTRANS_IDLE,   3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 32'h0,         1);
    step("err2",         1,   0,  32'h4000_0000, HTRANS_IDLE,   3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 32'h0,         1);
    step("after_err",    1,   0,  32'h1F80_0004, HTRANS_NONSEQ, 3'b111, 3'b000, 3'b100, 3'b100, 1'b1, 1'b0, 32'h0,         1);
    step("b2b_gpio",     1,   0,  32'h1FC0_0000, HTRANS_NONSEQ, 3'b111, 3'b000, 3'b001, 3'b001, 1'b1, 1'b0, 32'h6A10_0002, 1);
    step("b2b_rom",      1,   0,  32'h4000_0000, HTRANS_NONSEQ, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 32'hC0DE_0000, 1);
    step("rst_mid_err1", 1,   1,  32'h1FC0_0010, HTRANS_IDLE,   3'b111, 3'b000, 3'b001, 3'b001, 1'b1, 1'b0, 32'h0,         1);
    step("rst_hold",     0,   0,  32'h4000_0000, HTRANS_IDLE,   3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 32'h0,         1);
    step("rst_release",  1,   0,  32'h4000_0000, HTRANS_NONSEQ, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 32'h0,         1);
    step("err1_b",       1,   0,  32'h4000_0004, HTRANS_SEQ,    3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 32'h0,         1);
    step("err2_b",       1,   0,  32'h4000_0004, HTRANS_SEQ,    3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 32'h0,         1);
    step("err1_c",       1,   0,  32'h0000_0040, HTRANS_NONSEQ, 3'b111, 3'b000, 3'b010, 3'b000, 1'b0, 1'b1, 32'h0,         1);
    step("err2_c",       1,   0,  32'h0000_0040, HTRANS_NONSEQ, 3'b111, 3'b000, 3'b010, 3'b000, 1'b1, 1'b1, 32'h0,         1);
    step("ram_err1",     1,   0,  32'h1FC0_8000, HTRANS_BUSY,   3'b101, 3'b010, 3'b000, 3'b010, 1'b0, 1'b1, 32'h0,         0);
    step("ram_err2",     1,   0,  32'h1FC0_8000, HTRANS_IDLE,   3'b111, 3'b010, 3'b000, 3'b010, 1'b1, 1'b1, 32'hDEAD_BEEF, 1);
    step("final_ok",     1,   0,  32'h4000_0000, HTRANS_IDLE,   3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 32'h0,         1);

    repeat (4) @(negedge HCLK);
    #1;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
